ycr_dmem_wb_pipe: RTL and testbench

Single-clock, parametrised, pipelined bridge from the core data-memory interface to the Wishbone data bus. It replaces the async dual-FIFO bridge for builds where core and bus share one clock. It accepts back-to-back requests at one per cycle and supports a 32- or 64-bit data path. It adds a programmable bus timeout that converts a hung slave into an error response.

---
 rtl/ycr_dmem_wb_pipe.sv | 174 +++++++++++++++++
 tb/tb_ycr_dmem_wb_pipe.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycr_dmem_wb_pipe.sv
// Single-clock pipelined bridge from the core data-memory port to Wishbone.
// Request FIFO feeds the bus, response FIFO drains to the core every cycle, with a bus-hang timeout.
module ycr_dmem_wb_pipe #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int BLW       = 10,
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TMO_W     = 8
) (
  input  logic              core_clk,
  input  logic              core_rst_n,
  input  logic              dmem_req,
  output logic              dmem_req_ack,
  input  logic              dmem_cmd,
  input  logic [1:0]        dmem_width,
  input  logic [AW-1:0]     dmem_addr,
  input  logic [BLW-1:0]    dmem_bl,
  input  logic [DW-1:0]     dmem_wdata,
  output logic [DW-1:0]     dmem_rdata,
  output logic [1:0]        dmem_resp,
  output logic              wbd_stb_o,
  output logic              wbd_we_o,
  output logic [AW-1:0]     wbd_adr_o,
  output logic [DW-1:0]     wbd_dat_o,
  output logic [DW/8-1:0]   wbd_sel_o,
  output logic [BLW-1:0]    wbd_bl_o,
  output logic              wbd_bry_o,
  input  logic [DW-1:0]     wbd_dat_i,
  input  logic              wbd_ack_i,
  input  logic              wbd_lack_i,
  input  logic              wbd_err_i,
  input  logic [TMO_W-1:0]  cfg_tmo,
  output logic              tmo_evt
);
  localparam int SW  = DW / 8;
  localparam int OW  = $clog2(SW);
  localparam int QPW = $clog2(REQ_DEPTH);
  localparam int RPW = $clog2(RSP_DEPTH);
  localparam logic [1:0] RESP_NOTRDY = 2'b00;
  localparam logic [1:0] RESP_OK     = 2'b01;
  localparam logic [1:0] RESP_ER     = 2'b10;
  localparam logic [1:0] RESP_LOK    = 2'b11;
  localparam logic       CMD_WR      = 1'b1;
  localparam logic [RPW:0] RSP_LIM   = (RPW+1)'(RSP_DEPTH - 2);

  function automatic logic [SW-1:0] lane_sel(input logic [1:0] width, input logic [OW-1:0] off);
    logic [7:0] base;
    case (width)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      default: base = (DW == 64) ? 8'hFF : 8'h0F;
    endcase
    return SW'(base << off);
  endfunction

  function automatic logic [DW-1:0] lane_mask(input logic [1:0] width);
    logic [SW-1:0] s;
    logic [DW-1:0] m;
    s = lane_sel(width, '0);
    for (int i = 0; i < SW; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  // ---- request FIFO: core side push, bus side head ----
  logic [AW-1:0]  rq_addr  [REQ_DEPTH];
  logic [DW-1:0]  rq_data  [REQ_DEPTH];
  logic [SW-1:0]  rq_sel   [REQ_DEPTH];
  logic [BLW-1:0] rq_bl    [REQ_DEPTH];
  logic [1:0]     rq_width [REQ_DEPTH];
  logic           rq_we    [REQ_DEPTH];
  logic [QPW:0]   rq_wp, rq_rp;
  logic [QPW-1:0] rq_head;
  logic           rq_empty, rq_full, rq_push, rq_pop;

  logic [1:0]     rs_resp  [RSP_DEPTH];
  logic [1:0]     rs_width [RSP_DEPTH];
  logic [OW-1:0]  rs_off   [RSP_DEPTH];
  logic [DW-1:0]  rs_data  [RSP_DEPTH];
  logic [RPW:0]   rs_wp, rs_rp, rs_cnt;
  logic [RPW-1:0] rs_tail;
  logic           rs_empty, rs_full, rs_room2, rs_push, rs_pop;

  logic             stb, bus_done, tmo_hit;
  logic [TMO_W-1:0] tmo_cnt;

  assign rq_head  = rq_rp[QPW-1:0];
  assign rq_empty = (rq_wp == rq_rp);
  assign rq_full  = (rq_wp[QPW] != rq_rp[QPW]) && (rq_wp[QPW-1:0] == rq_rp[QPW-1:0]);
  assign dmem_req_ack = dmem_req & ~rq_full;
  assign rq_push  = dmem_req_ack;

  always_ff @(posedge core_clk) begin
    if (rq_push) begin
      rq_addr[rq_wp[QPW-1:0]]  <= dmem_addr;
      rq_data[rq_wp[QPW-1:0]]  <= (dmem_wdata & lane_mask(dmem_width)) << {dmem_addr[OW-1:0], 3'b000};
      rq_sel[rq_wp[QPW-1:0]]   <= lane_sel(dmem_width, dmem_addr[OW-1:0]);
      rq_bl[rq_wp[QPW-1:0]]    <= dmem_bl;
      rq_width[rq_wp[QPW-1:0]] <= dmem_width;
      rq_we[rq_wp[QPW-1:0]]    <= (dmem_cmd == CMD_WR);
    end
  end

  // ---- bus stage: head drives Wishbone, completions and timeouts feed response FIFO ----
  assign stb       = ~rq_empty & ~rs_full;
  assign wbd_stb_o = stb;
  assign wbd_we_o  = ~rq_empty & rq_we[rq_head];
  assign wbd_adr_o = rq_empty ? '0 : rq_addr[rq_head];
  assign wbd_dat_o = rq_empty ? '0 : rq_data[rq_head];
  assign wbd_sel_o = rq_empty ? '0 : rq_sel[rq_head];
  assign wbd_bl_o  = rq_empty ? '0 : rq_bl[rq_head];
  // Reads need room for the beat in flight plus the next one before the slave may burst on.
  assign wbd_bry_o = ~rq_empty & (rq_we[rq_head] | rs_room2);

  assign bus_done = stb & (wbd_ack_i | wbd_lack_i | wbd_err_i);
  assign tmo_hit  = stb & (cfg_tmo != '0) & (tmo_cnt == cfg_tmo - TMO_W'(1)) & ~bus_done;
  assign rq_pop   = (stb & (wbd_lack_i | wbd_err_i)) | tmo_hit;
  assign rs_push  = bus_done | tmo_hit;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      rq_wp   <= '0;
      rq_rp   <= '0;
      tmo_cnt <= '0;
      tmo_evt <= 1'b0;
    end else begin
      if (rq_push) rq_wp <= rq_wp + 1'b1;
      if (rq_pop)  rq_rp <= rq_rp + 1'b1;
      if (~rq_empty & rs_full)             tmo_cnt <= tmo_cnt;
      else if (~stb | bus_done | tmo_hit) tmo_cnt <= '0;
      else                                tmo_cnt <= tmo_cnt + TMO_W'(1);
      tmo_evt <= tmo_hit;
    end
  end

  assign rs_tail  = rs_wp[RPW-1:0];
  assign rs_empty = (rs_wp == rs_rp);
  assign rs_full  = (rs_wp[RPW] != rs_rp[RPW]) && (rs_wp[RPW-1:0] == rs_rp[RPW-1:0]);
  assign rs_cnt   = rs_wp - rs_rp;
  assign rs_room2 = (rs_cnt <= RSP_LIM);
  assign rs_pop   = ~rs_empty;

  always_ff @(posedge core_clk) begin
    if (rs_push) begin
      rs_resp[rs_tail]  <= (wbd_err_i | tmo_hit) ? RESP_ER : (wbd_lack_i ? RESP_LOK : RESP_OK);
      rs_width[rs_tail] <= rq_width[rq_head];
      rs_off[rs_tail]   <= rq_addr[rq_head][OW-1:0];
      rs_data[rs_tail]  <= (wbd_err_i | tmo_hit | rq_we[rq_head]) ? '0 : wbd_dat_i;
    end
  end

  // ---- drain stage: registered response and lane-extracted read data ----
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      rs_wp      <= '0;
      rs_rp      <= '0;
      dmem_resp  <= RESP_NOTRDY;
      dmem_rdata <= '0;
    end else begin
      if (rs_push) rs_wp <= rs_wp + 1'b1;
      if (rs_pop) begin
        rs_rp      <= rs_rp + 1'b1;
        dmem_resp  <= rs_resp[rs_rp[RPW-1:0]];
        dmem_rdata <= (rs_data[rs_rp[RPW-1:0]] >> {rs_off[rs_rp[RPW-1:0]], 3'b000})
                      & lane_mask(rs_width[rs_rp[RPW-1:0]]);
      end else begin
        dmem_resp  <= RESP_NOTRDY;
        dmem_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ycr_dmem_wb_pipe.sv
// Bench for ycr_dmem_wb_pipe: random and directed traffic against a queue-based bridge model.
// A 64-bit instance covers the dword lane rules.
`timescale 1ns/1ps
module tb_ycr_dmem_wb_pipe;
  localparam int DW = 32, AW = 32, BLW = 10, REQ_DEPTH = 4, RSP_DEPTH = 4, TMO_W = 8;
  localparam logic [1:0] NOTRDY = 2'b00, R_OK = 2'b01, R_ER = 2'b10, R_LOK = 2'b11;
  localparam int M_RAND = 0, M_ZERO = 1, M_HANG = 2, M_DLY = 3;

  logic core_clk = 1'b0;
  logic core_rst_n = 1'b0;
  always #5 core_clk = ~core_clk;

  logic              dmem_req, dmem_req_ack, dmem_cmd;
  logic [1:0]        dmem_width, dmem_resp;
  logic [AW-1:0]     dmem_addr;
  logic [BLW-1:0]    dmem_bl;
  logic [DW-1:0]     dmem_wdata, dmem_rdata;
  logic              wbd_stb_o, wbd_we_o, wbd_bry_o;
  logic [AW-1:0]     wbd_adr_o;
  logic [DW-1:0]     wbd_dat_o, wbd_dat_i;
  logic [DW/8-1:0]   wbd_sel_o;
  logic [BLW-1:0]    wbd_bl_o;
  logic              wbd_ack_i, wbd_lack_i, wbd_err_i;
  logic [TMO_W-1:0]  cfg_tmo;
  logic              tmo_evt;

  ycr_dmem_wb_pipe #(.DW(DW), .AW(AW), .BLW(BLW), .REQ_DEPTH(REQ_DEPTH),
                     .RSP_DEPTH(RSP_DEPTH), .TMO_W(TMO_W)) u_dut (
    .core_clk(core_clk), .core_rst_n(core_rst_n),
    .dmem_req(dmem_req), .dmem_req_ack(dmem_req_ack), .dmem_cmd(dmem_cmd),
    .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_bl(dmem_bl),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .wbd_stb_o(wbd_stb_o), .wbd_we_o(wbd_we_o), .wbd_adr_o(wbd_adr_o),
    .wbd_dat_o(wbd_dat_o), .wbd_sel_o(wbd_sel_o), .wbd_bl_o(wbd_bl_o),
    .wbd_bry_o(wbd_bry_o), .wbd_dat_i(wbd_dat_i), .wbd_ack_i(wbd_ack_i),
    .wbd_lack_i(wbd_lack_i), .wbd_err_i(wbd_err_i), .cfg_tmo(cfg_tmo), .tmo_evt(tmo_evt)
  );

  logic              q_req, q_req_ack, q_cmd;
  logic [1:0]        q_width, q_resp;
  logic [AW-1:0]     q_addr;
  logic [BLW-1:0]    q_bl;
  logic [63:0]       q_wdata, q_rdata, q_dat_o, q_dat_i;
  logic              q_stb, q_we, q_bry;
  logic [AW-1:0]     q_adr;
  logic [7:0]        q_sel;
  logic [BLW-1:0]    q_bl_o;
  logic              q_ack, q_lack, q_err;
  logic              q_tmo_evt;

  ycr_dmem_wb_pipe #(.DW(64), .AW(AW), .BLW(BLW), .REQ_DEPTH(REQ_DEPTH),
                     .RSP_DEPTH(RSP_DEPTH), .TMO_W(TMO_W)) u_dut64 (
    .core_clk(core_clk), .core_rst_n(core_rst_n),
    .dmem_req(q_req), .dmem_req_ack(q_req_ack), .dmem_cmd(q_cmd),
    .dmem_width(q_width), .dmem_addr(q_addr), .dmem_bl(q_bl),
    .dmem_wdata(q_wdata), .dmem_rdata(q_rdata), .dmem_resp(q_resp),
    .wbd_stb_o(q_stb), .wbd_we_o(q_we), .wbd_adr_o(q_adr),
    .wbd_dat_o(q_dat_o), .wbd_sel_o(q_sel), .wbd_bl_o(q_bl_o),
    .wbd_bry_o(q_bry), .wbd_dat_i(q_dat_i), .wbd_ack_i(q_ack),
    .wbd_lack_i(q_lack), .wbd_err_i(q_err), .cfg_tmo(8'd0), .tmo_evt(q_tmo_evt)
  );

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { bit we; bit [1:0] width; bit [31:0] addr; int bl; bit [31:0] wdata; } req_t;
  typedef struct { bit [1:0] resp; bit [31:0] rdata; int due; } rsp_t;
  typedef struct { bit [1:0] resp; bit [31:0] rdata; int cyc; } log_t;

  req_t pend[$];
  req_t mq[$];
  rsp_t eq[$];
  log_t rlog[$];
  int cyc = 0, beats = 0, tcnt = 0, tmo_seen = 0, mode = M_ZERO, dly = 0;
  bit fix_en = 0;
  bit [31:0] fix_dat = 0;

  function automatic req_t mk(bit we, bit [1:0] w, bit [31:0] a, int bl, bit [31:0] d);
    req_t r;
    r.we = we; r.width = w; r.addr = a; r.bl = bl; r.wdata = d;
    return r;
  endfunction

  function automatic int nbytes(bit [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit [3:0] m_sel(req_t r);
    bit [63:0] v;
    v = ((64'd1 << nbytes(r.width)) - 64'd1) << (r.addr % 4);
    return v[3:0];
  endfunction

  function automatic bit [31:0] m_dat(req_t r);
    bit [63:0] v;
    v = ({32'd0, r.wdata} & ((64'd1 << (8 * nbytes(r.width))) - 64'd1)) << (8 * (r.addr % 4));
    return v[31:0];
  endfunction

  function automatic bit [31:0] m_rd(req_t r, bit [31:0] bus);
    bit [63:0] v;
    v = ({32'd0, bus} >> (8 * (r.addr % 4))) & ((64'd1 << (8 * nbytes(r.width))) - 64'd1);
    return v[31:0];
  endfunction

  // One clock of traffic: drive at negedge, check bus side, advance model, check core side.
  task automatic tick();
    bit stb_e, a, l, e, go, last, fire, acc;
    int r;
    req_t h;
    rsp_t x;
    log_t lg;
    stb_e = (mq.size() != 0);
    if (pend.size() != 0) begin
      dmem_req = 1'b1; dmem_cmd = pend[0].we; dmem_width = pend[0].width;
      dmem_addr = pend[0].addr; dmem_bl = BLW'(pend[0].bl); dmem_wdata = pend[0].wdata;
    end else begin
      dmem_req = 1'b0;
    end
    a = 0; l = 0; e = 0; go = 0;
    if (stb_e) begin
      h = mq[0];
      last = (beats + 1 >= h.bl);
      case (mode)
        M_ZERO:  go = 1;
        M_HANG:  go = 0;
        M_DLY:   go = (tcnt == dly);
        default: begin r = $urandom_range(0, 9); go = (r < 6); e = (r == 6); end
      endcase
      if (go) begin a = 1; l = last; end
    end
    wbd_dat_i = fix_en ? fix_dat : $urandom;
    wbd_ack_i = a; wbd_lack_i = l; wbd_err_i = e;
    #1;
    acc = (pend.size() != 0) && (mq.size() < REQ_DEPTH);
    check("req_ack", dmem_req_ack, acc);
    check("stb", wbd_stb_o, stb_e);
    if (stb_e) begin
      check("adr", wbd_adr_o, h.addr);
      check("we", wbd_we_o, h.we);
      check("sel", wbd_sel_o, m_sel(h));
      check("dat", wbd_dat_o, m_dat(h));
      check("bl", wbd_bl_o, h.bl);
      check("bry", wbd_bry_o, 1);
    end else begin
      check("adr_idle", wbd_adr_o, 0);
      check("sel_idle", wbd_sel_o, 0);
      check("bry_idle", wbd_bry_o, 0);
    end
    fire = 0;
    if (stb_e) begin
      if (a || e) begin
        x.resp = e ? R_ER : (l ? R_LOK : R_OK);
        x.rdata = (e || h.we) ? 32'd0 : m_rd(h, wbd_dat_i);
        x.due = cyc + 2;
        eq.push_back(x);
        tcnt = 0;
        if (l || e) begin void'(mq.pop_front()); beats = 0; end
        else beats++;
      end else if (cfg_tmo != 0 && tcnt == cfg_tmo - 1) begin
        fire = 1;
        x.resp = R_ER; x.rdata = 0; x.due = cyc + 2;
        eq.push_back(x);
        void'(mq.pop_front());
        beats = 0; tcnt = 0;
      end else begin
        tcnt++;
      end
    end else begin
      tcnt = 0;
    end
    if (acc) mq.push_back(pend.pop_front());
    @(posedge core_clk);
    @(negedge core_clk);
    cyc++;
    wbd_ack_i = 0; wbd_lack_i = 0; wbd_err_i = 0;
    check("tmo_evt", tmo_evt, fire);
    if (fire) tmo_seen++;
    if (dmem_resp != NOTRDY) begin
      lg.resp = dmem_resp; lg.rdata = dmem_rdata; lg.cyc = cyc;
      rlog.push_back(lg);
    end
    if (eq.size() != 0 && eq[0].due == cyc) begin
      x = eq.pop_front();
      check("resp", dmem_resp, x.resp);
      check("rdata", dmem_rdata, x.rdata);
    end else begin
      check("resp_idle", dmem_resp, NOTRDY);
      check("rdata_idle", dmem_rdata, 0);
    end
  endtask

  task automatic drain();
    mode = M_ZERO;
    for (int i = 0; i < 100 && (pend.size() + mq.size() + eq.size()) != 0; i++) tick();
    check("drain", pend.size() + mq.size() + eq.size(), 0);
  endtask

  task automatic run64(input string tag, input bit [31:0] addr, input bit [1:0] w,
                       input bit [63:0] bus, input bit [7:0] exp_sel, input bit [63:0] exp_rd);
    bit got;
    @(negedge core_clk);
    q_req = 1; q_cmd = 0; q_addr = addr; q_width = w; q_bl = 1;
    #1 check({tag, "_ack"}, q_req_ack, 1);
    @(negedge core_clk);
    q_req = 0;
    check({tag, "_stb"}, q_stb, 1);
    check({tag, "_sel"}, q_sel, exp_sel);
    q_ack = 1; q_lack = 1; q_dat_i = bus;
    @(negedge core_clk);
    q_ack = 0; q_lack = 0;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      if (q_resp != NOTRDY) begin
        got = 1;
        check({tag, "_resp"}, q_resp, R_LOK);
        check({tag, "_rdata"}, q_rdata, exp_rd);
      end else begin
        @(negedge core_clk);
      end
    end
    check({tag, "_resp_seen"}, got, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, t0;
    bit [1:0] tmo_tab [4];
    dmem_req = 0; dmem_cmd = 0; dmem_width = 0; dmem_addr = 0; dmem_bl = 0; dmem_wdata = 0;
    wbd_dat_i = 0; wbd_ack_i = 0; wbd_lack_i = 0; wbd_err_i = 0; cfg_tmo = 0;
    q_req = 0; q_cmd = 0; q_width = 0; q_addr = 0; q_bl = 0; q_wdata = 0;
    q_dat_i = 0; q_ack = 0; q_lack = 0; q_err = 0;
    repeat (3) @(negedge core_clk);
    check("rst_req_ack", dmem_req_ack, 0);
    check("rst_stb", wbd_stb_o, 0);
    check("rst_we", wbd_we_o, 0);
    check("rst_adr", wbd_adr_o, 0);
    check("rst_dat", wbd_dat_o, 0);
    check("rst_sel", wbd_sel_o, 0);
    check("rst_bl", wbd_bl_o, 0);
    check("rst_bry", wbd_bry_o, 0);
    check("rst_resp", dmem_resp, NOTRDY);
    check("rst_rdata", dmem_rdata, 0);
    check("rst_tmo_evt", tmo_evt, 0);
    core_rst_n = 1;
    @(negedge core_clk);

    mode = M_ZERO; rlog.delete();
    pend.push_back(mk(1, 2'd0, 32'h1003, 1, 32'h000000AB));
    pend.push_back(mk(1, 2'd1, 32'h2002, 1, 32'h00001234));
    n0 = cyc;
    tick();
    check("b2b_sel1", wbd_sel_o, 4'h8);
    check("b2b_dat1", wbd_dat_o, 32'hAB000000);
    tick();
    check("b2b_sel2", wbd_sel_o, 4'hC);
    check("b2b_dat2", wbd_dat_o, 32'h12340000);
    repeat (4) tick();
    check("b2b_nresp", rlog.size(), 2);
    if (rlog.size() == 2) begin
      check("b2b_resp1", rlog[0].resp, R_LOK);
      check("b2b_lat1", rlog[0].cyc - n0, 3);
      check("b2b_resp2", rlog[1].resp, R_LOK);
      check("b2b_lat2", rlog[1].cyc - n0, 4);
    end

    rlog.delete(); fix_en = 1; fix_dat = 32'hDDCCBBAA;
    pend.push_back(mk(0, 2'd0, 32'h1001, 1, 32'h0));
    repeat (5) tick();
    fix_en = 0;
    check("byte_nresp", rlog.size(), 1);
    if (rlog.size() == 1) begin
      check("byte_resp", rlog[0].resp, R_LOK);
      check("byte_rdata", rlog[0].rdata, 32'h000000BB);
    end

    rlog.delete();
    pend.push_back(mk(0, 2'd2, 32'h3000, 4, 32'h0));
    repeat (8) tick();
    check("burst_nresp", rlog.size(), 4);
    if (rlog.size() == 4) begin
      check("burst_r0", rlog[0].resp, R_OK);
      check("burst_r1", rlog[1].resp, R_OK);
      check("burst_r2", rlog[2].resp, R_OK);
      check("burst_r3", rlog[3].resp, R_LOK);
    end

    cfg_tmo = 8'd5; mode = M_HANG; rlog.delete(); t0 = tmo_seen;
    pend.push_back(mk(0, 2'd2, 32'h4000, 1, 32'h0));
    pend.push_back(mk(0, 2'd2, 32'h4004, 1, 32'h0));
    for (int i = 0; i < 20 && tmo_seen == t0; i++) tick();
    check("tmo_fired", tmo_seen - t0, 1);
    mode = M_ZERO;
    repeat (6) tick();
    check("tmo_nresp", rlog.size(), 2);
    if (rlog.size() == 2) begin
      check("tmo_resp", rlog[0].resp, R_ER);
      check("tmo_rdata", rlog[0].rdata, 0);
      check("tmo_next_resp", rlog[1].resp, R_LOK);
    end
    mode = M_DLY; dly = 4; rlog.delete(); t0 = tmo_seen;
    pend.push_back(mk(0, 2'd2, 32'h4008, 1, 32'h0));
    repeat (10) tick();
    check("ack5_no_tmo", tmo_seen - t0, 0);
    check("ack5_nresp", rlog.size(), 1);
    if (rlog.size() == 1) check("ack5_resp", rlog[0].resp, R_LOK);
    drain();

    cfg_tmo = 0; mode = M_HANG;
    for (int i = 0; i < 5; i++) pend.push_back(mk(1, 2'd2, 32'h5000 + 4 * i, 1, $urandom));
    repeat (8) tick();
    check("bp_pending", pend.size(), 1);
    check("bp_ack_low", dmem_req_ack, 0);
    mode = M_ZERO;
    tick();
    check("bp_after_pop", pend.size(), 1);
    tick();
    check("bp_accepted", pend.size(), 0);
    drain();

    mode = M_HANG;
    pend.push_back(mk(0, 2'd2, 32'h6000, 1, 32'h0));
    pend.push_back(mk(0, 2'd2, 32'h6004, 1, 32'h0));
    repeat (3) tick();
    core_rst_n = 0; dmem_req = 0;
    #1;
    check("mid_rst_stb", wbd_stb_o, 0);
    check("mid_rst_sel", wbd_sel_o, 0);
    check("mid_rst_resp", dmem_resp, NOTRDY);
    pend.delete(); mq.delete(); eq.delete(); beats = 0; tcnt = 0;
    @(negedge core_clk);
    core_rst_n = 1;
    @(negedge core_clk);
    mode = M_ZERO;
    repeat (2) tick();

    tmo_tab[0] = 2'd0; tmo_tab[1] = 2'd3; tmo_tab[2] = 2'd1; tmo_tab[3] = 2'd2;
    for (int s = 0; s < 4; s++) begin
      cfg_tmo = (tmo_tab[s] == 2'd0) ? 8'd0 : (tmo_tab[s] == 2'd1) ? 8'd1 :
                (tmo_tab[s] == 2'd2) ? 8'd6 : 8'd3;
      mode = M_RAND;
      repeat (150) begin
        if (pend.size() < 3 && $urandom_range(0, 9) < 4) begin
          bit we;
          we = $urandom_range(0, 1) == 1;
          pend.push_back(mk(we, 2'($urandom_range(0, 2)), $urandom,
                            we ? 1 : $urandom_range(1, 3), $urandom));
        end
        tick();
      end
      drain();
    end

    run64("dw64_dword", 32'h08, 2'd3, 64'h1122334455667788, 8'hFF, 64'h1122334455667788);
    run64("dw64_byte", 32'h0D, 2'd0, 64'h1122334455667788, 8'h20, 64'h33);
    run64("dw64_word", 32'h04, 2'd2, 64'h1122334455667788, 8'hF0, 64'h11223344);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
